timer_ctrl: RTL and testbench

Sequencing controller for the PWM_Timer timer path. It owns the main counter and a clock prescaler, and runs a RUN/HOLD/IDLE state machine for continuous and one-shot modes. It generates the timer output pulse and the sticky interrupt flag from the Wishbone control and period registers. It sits between the register file (ctrl, period, divisor) and o_pwm / ctrl[5], in the chosen_clk domain.

---
 rtl/timer_ctrl.sv | 152 +++++++++++++++
 tb/tb_timer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: main counter, clock prescaler and IDLE/RUN/HOLD sequencer for
// the PWM timer path. It produces the one-cycle timer pulse and the sticky
// interrupt flag. Everything runs in the chosen_clk domain.
module timer_ctrl #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             chosen_clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             cont,
  input  logic             out_en,
  input  logic             cnt_rst,
  input  logic             irq_clr,
  input  logic [CNT_W-1:0] period_reg,
  input  logic [DIV_W-1:0] divisor_reg,
  output logic [CNT_W-1:0] counter,
  output logic             timer,
  output logic             irq_flag,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state;
  state_t           state_next;
  logic             en_s;
  logic [CNT_W-1:0] per_s;
  logic [DIV_W-1:0] div_s;
  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] pre_next;
  logic [CNT_W-1:0] counter_next;
  logic [CNT_W-1:0] per_last;
  logic [DIV_W-1:0] div_last;
  logic             tick;
  logic             expire;

  // Last counter value of a period; a zero period behaves as a period of one.
  function automatic logic [CNT_W-1:0] cnt_last(input logic [CNT_W-1:0] p);
    return (p == '0) ? '0 : p - CNT_ONE;
  endfunction

  // Last prescaler value of a divide cycle; a zero divisor behaves as one.
  function automatic logic [DIV_W-1:0] div_last_of(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_ONE;
  endfunction

  // Register the register-file inputs once so all decisions use stable copies.
  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) begin
      en_s  <= 1'b0;
      per_s <= '0;
      div_s <= '0;
    end else begin
      en_s  <= timer_en;
      per_s <= period_reg;
      div_s <= divisor_reg;
    end
  end

  // Prescaler tick and expiry; >= on the counter catches a shrunken period.
  always_comb begin
    per_last = cnt_last(per_s);
    div_last = div_last_of(div_s);
    tick     = (state == RUN) && (pre >= div_last);
    expire   = tick && en_s && !cnt_rst && (counter >= per_last);
  end

  // Next state, counter and prescaler; within RUN: disable > restart > expire > tick.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    pre_next     = '0;
    case (state)
      IDLE: begin
        counter_next = '0;
        if (en_s) state_next = RUN;
      end
      RUN: begin
        if (!en_s) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (cnt_rst) begin
          counter_next = '0;
        end else begin
          pre_next = tick ? '0 : pre + DIV_ONE;
          if (expire && cont) begin
            counter_next = '0;
          end else if (expire) begin
            state_next = HOLD;
          end else if (tick) begin
            counter_next = counter + CNT_ONE;
          end
        end
      end
      HOLD: begin
        if (!en_s) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (cnt_rst) begin
          state_next   = RUN;
          counter_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Counter and prescaler registers.
  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
      pre     <= '0;
    end else begin
      counter <= counter_next;
      pre     <= pre_next;
    end
  end

  // Output pulse, sticky interrupt (set beats clear) and registered state decodes.
  always_ff @(posedge chosen_clk or negedge rst) begin
    if (!rst) begin
      timer    <= 1'b0;
      irq_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      timer    <= expire && out_en;
      irq_flag <= expire ? 1'b1 : (irq_clr ? 1'b0 : irq_flag);
      busy     <= (state_next != IDLE);
      done     <= (state_next == HOLD);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: continuous and one-shot runs, interrupt
// set/clear, output gating, period shrink, zero period/divisor, disable
// and asynchronous reset.
module tb_timer_ctrl;
  localparam int CNT_W = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             timer_en;
  logic             cont;
  logic             out_en;
  logic             cnt_rst;
  logic             irq_clr;
  logic [CNT_W-1:0] period_reg;
  logic [DIV_W-1:0] divisor_reg;
  logic [CNT_W-1:0] counter;
  logic             timer;
  logic             irq_flag;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .chosen_clk (clk),
    .rst        (rst),
    .timer_en   (timer_en),
    .cont       (cont),
    .out_en     (out_en),
    .cnt_rst    (cnt_rst),
    .irq_clr    (irq_clr),
    .period_reg (period_reg),
    .divisor_reg(divisor_reg),
    .counter    (counter),
    .timer      (timer),
    .irq_flag   (irq_flag),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cont_cnt [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int shot_cnt [7]  = '{0, 0, 1, 1, 2, 2, 2};

    rst = 1'b0; timer_en = 1'b0; cont = 1'b0; out_en = 1'b0;
    cnt_rst = 1'b0; irq_clr = 1'b0; period_reg = '0; divisor_reg = '0;
    #2;
    check("reset_counter", 32'(counter), 0);
    check("reset_timer", 32'(timer), 0);
    check("reset_irq", 32'(irq_flag), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    step();
    rst = 1'b1;
    step();

    // Continuous, period 4, divisor 1; timer_en sampled at edge 0.
    cont = 1'b1; out_en = 1'b1; period_reg = 16'd4; divisor_reg = 16'd1; timer_en = 1'b1;
    step();
    check("e0_busy_idle", 32'(busy), 0);
    for (int e = 1; e <= 13; e++) begin
      step();
      check($sformatf("cont_counter_e%0d", e), 32'(counter), 32'(cont_cnt[e-1]));
      check($sformatf("cont_timer_e%0d", e), 32'(timer),
            (e == 5 || e == 9 || e == 13) ? 32'd1 : 32'd0);
      if (e == 1) check("e1_busy", 32'(busy), 1);
      if (e == 4) check("e4_irq_clear", 32'(irq_flag), 0);
      if (e == 5) check("e5_irq_set", 32'(irq_flag), 1);
    end

    // irq_clr coincident with expire at edge 17: set wins; edge 18 clears.
    step(); step(); step();
    irq_clr = 1'b1;
    step();
    check("e17_timer", 32'(timer), 1);
    check("e17_irq_set_wins", 32'(irq_flag), 1);
    step();
    check("e18_irq_cleared", 32'(irq_flag), 0);
    irq_clr = 1'b0; out_en = 1'b0;
    for (int e = 19; e <= 21; e++) begin
      step();
      check($sformatf("gated_timer_e%0d", e), 32'(timer), 0);
    end
    check("e21_irq_gated", 32'(irq_flag), 1);
    check("e21_counter", 32'(counter), 0);

    // Period 10, then shrink to 5 with the counter at 7.
    out_en = 1'b1; irq_clr = 1'b1; period_reg = 16'd10;
    step();
    check("e22_irq_cleared", 32'(irq_flag), 0);
    check("e22_counter", 32'(counter), 1);
    irq_clr = 1'b0;
    repeat (6) step();
    check("e28_counter", 32'(counter), 7);
    period_reg = 16'd5;
    step();
    check("e29_counter", 32'(counter), 8);
    check("e29_timer", 32'(timer), 0);
    step();
    check("e30_shrink_wrap", 32'(counter), 0);
    check("e30_shrink_timer", 32'(timer), 1);
    check("e30_irq", 32'(irq_flag), 1);

    // Drop timer_en mid-count.
    step(); step();
    check("e32_counter", 32'(counter), 2);
    timer_en = 1'b0;
    step();
    check("e33_counter", 32'(counter), 3);
    check("e33_busy", 32'(busy), 1);
    step();
    check("e34_idle_counter", 32'(counter), 0);
    check("e34_idle_busy", 32'(busy), 0);
    check("e34_irq_kept", 32'(irq_flag), 1);
    check("e34_timer", 32'(timer), 0);

    // One-shot, period 3, divisor 2; timer_en sampled at edge 35.
    cont = 1'b0; period_reg = 16'd3; divisor_reg = 16'd2; timer_en = 1'b1; irq_clr = 1'b1;
    step();
    check("e35_irq_cleared", 32'(irq_flag), 0);
    check("e35_busy", 32'(busy), 0);
    irq_clr = 1'b0;
    for (int e = 36; e <= 42; e++) begin
      step();
      check($sformatf("shot_counter_e%0d", e), 32'(counter), 32'(shot_cnt[e-36]));
      check($sformatf("shot_timer_e%0d", e), 32'(timer), (e == 42) ? 32'd1 : 32'd0);
      if (e == 36) check("e36_busy", 32'(busy), 1);
      if (e == 41) check("e41_done", 32'(done), 0);
    end
    check("e42_done", 32'(done), 1);
    check("e42_irq", 32'(irq_flag), 1);
    step(); step();
    check("e44_hold_counter", 32'(counter), 2);
    check("e44_hold_done", 32'(done), 1);
    check("e44_hold_timer", 32'(timer), 0);
    cnt_rst = 1'b1;
    step();
    check("e45_restart_done", 32'(done), 0);
    check("e45_restart_busy", 32'(busy), 1);
    check("e45_restart_counter", 32'(counter), 0);
    cnt_rst = 1'b0;
    step();
    check("e46_counter", 32'(counter), 0);
    step();
    check("e47_counter", 32'(counter), 1);

    // Zero period and divisor act as one: timer stays high.
    cont = 1'b1; period_reg = 16'd0; divisor_reg = 16'd0;
    step();
    check("e48_timer", 32'(timer), 0);
    check("e48_counter", 32'(counter), 1);
    for (int e = 49; e <= 52; e++) begin
      step();
      check($sformatf("unit_timer_e%0d", e), 32'(timer), 1);
      check($sformatf("unit_counter_e%0d", e), 32'(counter), 0);
    end

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    check("async_counter", 32'(counter), 0);
    check("async_timer", 32'(timer), 0);
    check("async_irq", 32'(irq_flag), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    #5;
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
